// File: rtl/arinc_pkg.sv
// Shared types and constants for the ARINC-429 multi-channel receiver.
package arinc_pkg;

    localparam int unsigned WORD_W = 32;

    // Accepted line state as {line_a, line_b}
    typedef enum logic [1:0] {
        LnNull = 2'b00,
        LnZero = 2'b01,
        LnOne  = 2'b10,
        LnIll  = 2'b11
    } line_e;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDone
    } chan_st_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arinc_multi_rx_if.sv
// Received-word stream: valid/ready handshake with data, source channel and parity flag.
interface arinc_multi_rx_if #(
    parameter int unsigned CHW = 3
);
    logic                        valid;
    logic                        ready;
    logic [arinc_pkg::WORD_W-1:0] data;
    logic [CHW-1:0]              chan;
    logic                        par_err;

    modport master (output valid, output data, output chan, output par_err, input ready);
    modport slave  (input valid, input data, input chan, input par_err, output ready);
endinterface

// File: rtl/arinc_rx_chan.sv
// One receive channel: 2-FF sync, run-length glitch filter, RZ bit decode,
// word-assembly FSM and a single-word holding buffer drained by the top-level arbiter.
module arinc_rx_chan
    import arinc_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned GAP_CLKS = 2000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              line_a_i,
    input  logic              line_b_i,
    input  logic              grant_i,
    output logic              full_o,
    output logic [WORD_W-1:0] data_o,
    output logic              par_err_o,
    output logic              ovr_set_o
);

    localparam int unsigned GapW = clog2_min1(GAP_CLKS);

    logic [1:0]        sync1_q, sync2_q;
    line_e             cand_q, cand_d;
    logic [3:0]        fcnt_q, fcnt_d;
    line_e             lstate_q, lstate_d;
    logic [GapW-1:0]   null_cnt_q, null_cnt_d;
    chan_st_e          st_q, st_d;
    logic [4:0]        bcnt_q, bcnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic              buf_par_q, buf_par_d;
    logic              accept, bit_stb, gap_hit;
    logic [4:0]        bidx;

    // Filter: a new state is accepted on its FILT_LEN-th consecutive equal sample
    always_comb begin
        cand_d = line_e'(sync2_q);
        fcnt_d = fcnt_q;
        if (sync2_q != cand_q) begin
            fcnt_d = 4'd1;
        end else if (fcnt_q != 4'(FILT_LEN)) begin
            fcnt_d = fcnt_q + 4'd1;
        end
        accept   = (sync2_q == cand_q) && (fcnt_q == 4'(FILT_LEN - 1));
        lstate_d = accept ? cand_q : lstate_q;
        bit_stb  = accept && (lstate_q == LnNull) && ((cand_q == LnOne) || (cand_q == LnZero));

        null_cnt_d = null_cnt_q;
        if (lstate_q != LnNull) begin
            null_cnt_d = '0;
        end else if (null_cnt_q != GapW'(GAP_CLKS - 1)) begin
            null_cnt_d = null_cnt_q + GapW'(1);
        end
        gap_hit = (lstate_q == LnNull) && (null_cnt_q == GapW'(GAP_CLKS - 1));
    end

    always_comb begin
        st_d       = st_q;
        bcnt_d     = bcnt_q;
        word_d     = word_q;
        bidx       = gap_hit ? 5'd0 : bcnt_q;
        buf_full_d = buf_full_q & ~grant_i;
        buf_d      = buf_q;
        buf_par_d  = buf_par_q;
        ovr_set_o  = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (gap_hit) begin
                    st_d   = StRecv;
                    bcnt_d = '0;
                end
            end
            StRecv: begin
                if (lstate_q == LnIll) begin
                    st_d   = StIdle;
                    bcnt_d = '0;
                end else begin
                    bcnt_d = bidx;
                    if (bit_stb) begin
                        word_d[bidx] = (cand_q == LnOne);
                        if (bidx == 5'd31) begin
                            st_d   = StDone;
                            bcnt_d = '0;
                        end else begin
                            bcnt_d = bidx + 5'd1;
                        end
                    end
                end
            end
            StDone: begin
                st_d   = StRecv;
                bcnt_d = '0;
                // A buffer being granted this cycle is free to take the new word
                if (!buf_full_q || grant_i) begin
                    buf_full_d = 1'b1;
                    buf_d      = word_q;
                    buf_par_d  = ~^word_q;
                end else begin
                    ovr_set_o = 1'b1;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            cand_q     <= LnNull;
            fcnt_q     <= 4'(FILT_LEN);
            lstate_q   <= LnNull;
            null_cnt_q <= '0;
            st_q       <= StIdle;
            bcnt_q     <= '0;
            word_q     <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            buf_par_q  <= 1'b0;
        end else begin
            sync1_q    <= {line_a_i, line_b_i};
            sync2_q    <= sync1_q;
            cand_q     <= cand_d;
            fcnt_q     <= fcnt_d;
            lstate_q   <= lstate_d;
            null_cnt_q <= null_cnt_d;
            st_q       <= st_d;
            bcnt_q     <= bcnt_d;
            word_q     <= word_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            buf_par_q  <= buf_par_d;
        end
    end

    assign full_o    = buf_full_q;
    assign data_o    = buf_q;
    assign par_err_o = buf_par_q;

endmodule

// File: rtl/arinc_multi_rx.sv
// N-channel ARINC-429 receiver with round-robin merge onto one word stream.
// Define ARINC_REDUNDANT_EN to add line_a2_i/line_b2_i, ANDed with the primary lines.
module arinc_multi_rx
    import arinc_pkg::*;
#(
    parameter  int unsigned NCH      = 6,
    parameter  int unsigned FILT_LEN = 4,
    parameter  int unsigned GAP_CLKS = 2000,
    localparam int unsigned CHW      = clog2_min1(NCH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NCH-1:0]   line_a_i,
    input  logic [NCH-1:0]   line_b_i,
`ifdef ARINC_REDUNDANT_EN
    input  logic [NCH-1:0]   line_a2_i,
    input  logic [NCH-1:0]   line_b2_i,
`endif
    arinc_multi_rx_if.master out_io,
    output logic [NCH-1:0]   ovr_o,
    input  logic             ovr_clr_i
);

    localparam int unsigned PW = CHW + 1;

    logic [NCH-1:0]    line_a_eff, line_b_eff;
    logic [NCH-1:0]    buf_full, buf_par, ovr_set, grant;
    logic [WORD_W-1:0] buf_data [NCH];

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [CHW-1:0]    chan_q, chan_d;
    logic              par_q, par_d;
    logic [CHW-1:0]    rr_q, rr_d;
    logic [NCH-1:0]    ovr_q, ovr_d;
    logic              found, load;
    logic [CHW-1:0]    gsel;
    logic [PW-1:0]     probe, nxt;

`ifdef ARINC_REDUNDANT_EN
    assign line_a_eff = line_a_i & line_a2_i;
    assign line_b_eff = line_b_i & line_b2_i;
`else
    assign line_a_eff = line_a_i;
    assign line_b_eff = line_b_i;
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        arinc_rx_chan #(
            .FILT_LEN(FILT_LEN),
            .GAP_CLKS(GAP_CLKS)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .line_a_i (line_a_eff[c]),
            .line_b_i (line_b_eff[c]),
            .grant_i  (grant[c]),
            .full_o   (buf_full[c]),
            .data_o   (buf_data[c]),
            .par_err_o(buf_par[c]),
            .ovr_set_o(ovr_set[c])
        );
    end

    // First full buffer at or after the RR pointer, wrapping modulo NCH
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        probe = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            probe = {1'b0, rr_q} + PW'(i);
            if (probe >= PW'(NCH)) begin
                probe = probe - PW'(NCH);
            end
            if (!found && buf_full[probe[CHW-1:0]]) begin
                found = 1'b1;
                gsel  = probe[CHW-1:0];
            end
        end
    end

    always_comb begin
        load    = found && (!valid_q || out_io.ready);
        grant   = '0;
        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        par_d   = par_q;
        rr_d    = rr_q;
        nxt     = {1'b0, gsel} + PW'(1);
        if (nxt == PW'(NCH)) begin
            nxt = '0;
        end
        if (load) begin
            grant[gsel] = 1'b1;
            valid_d     = 1'b1;
            data_d      = buf_data[gsel];
            chan_d      = gsel;
            par_d       = buf_par[gsel];
            rr_d        = nxt[CHW-1:0];
        end else if (out_io.ready) begin
            valid_d = 1'b0;
        end
        // A new overrun wins over a simultaneous clear
        ovr_d = (ovr_q & ~{NCH{ovr_clr_i}}) | ovr_set;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            par_q   <= 1'b0;
            rr_q    <= '0;
            ovr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            par_q   <= par_d;
            rr_q    <= rr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_io.valid   = valid_q;
    assign out_io.data    = data_q;
    assign out_io.chan    = chan_q;
    assign out_io.par_err = par_q;
    assign ovr_o          = ovr_q;

endmodule
